// File: rtl/spi_flash_pkg.sv
// Shared opcodes, address limit and state encoding for the SPI flash responder.
// SPI_FAST_READ_EN adds the DUMMY state used by FAST READ (0x0B).
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;
    localparam logic [7:0] OP_RDSR      = 8'h05;

    localparam int SPI_ADDR_BITS = 24;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_ID     = 3'd3,
        ST_STATUS = 3'd4,
`ifdef SPI_FAST_READ_EN
        ST_IGNORE = 3'd5,
        ST_DUMMY  = 3'd6
`else
        ST_IGNORE = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/spi_flash_read_pipe.sv
// Fixed three-stage response pipe: trigger -> mem_rd -> rdata capture -> tx_strobe.
// Constant bytes (ID, status) ride the same stages so every response has one timing.
module spi_flash_read_pipe #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 trig_mem,
    input  logic                 trig_const,
    input  logic [7:0]           const_byte,
    input  logic [ADDR_BITS-1:0] trig_addr,
    output logic                 mem_rd,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 tx_strobe,
    output logic [7:0]           tx_data
);

    logic       s1_const_r;
    logic [7:0] s1_byte_r;
    logic       s2_mem_r;
    logic       s2_const_r;
    logic [7:0] s2_byte_r;

    // Stage 1: issue the memory read or hold the constant byte
    always_ff @(posedge mclk) begin
        if (reset) begin
            mem_rd     <= 1'b0;
            mem_addr   <= {ADDR_BITS{1'b0}};
            s1_const_r <= 1'b0;
            s1_byte_r  <= 8'h00;
        end else if (flush) begin
            mem_rd     <= 1'b0;
            s1_const_r <= 1'b0;
        end else begin
            mem_rd     <= trig_mem;
            s1_const_r <= trig_const;
            s1_byte_r  <= const_byte;
            if (trig_mem) begin
                mem_addr <= trig_addr;
            end
        end
    end

    // Stage 2: memory data is in flight, constant byte waits alongside
    always_ff @(posedge mclk) begin
        if (reset) begin
            s2_mem_r   <= 1'b0;
            s2_const_r <= 1'b0;
            s2_byte_r  <= 8'h00;
        end else if (flush) begin
            s2_mem_r   <= 1'b0;
            s2_const_r <= 1'b0;
        end else begin
            s2_mem_r   <= mem_rd;
            s2_const_r <= s1_const_r;
            s2_byte_r  <= s1_byte_r;
        end
    end

    // Stage 3: register the response byte and strobe it to spi_device
    always_ff @(posedge mclk) begin
        if (reset) begin
            tx_strobe <= 1'b0;
            tx_data   <= 8'h00;
        end else if (flush) begin
            tx_strobe <= 1'b0;
        end else begin
            tx_strobe <= s2_mem_r | s2_const_r;
            if (s2_mem_r) begin
                tx_data <= mem_rdata;
            end else if (s2_const_r) begin
                tx_data <= s2_byte_r;
            end
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// Byte-level SPI NOR command engine (READ, JEDEC ID, READ STATUS) behind spi_device.
// Define SPI_FAST_READ_EN to accept FAST READ (0x0B) with one dummy byte.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_BITS   = 16,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 rx_strobe,
    input  logic [7:0]           rx_data,
    output logic                 tx_strobe,
    output logic [7:0]           tx_data,
    output logic                 mem_rd,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 bad_cmd
);

    if (ADDR_BITS < 1 || ADDR_BITS > SPI_ADDR_BITS) begin : g_addr_bits_check
        $error("ADDR_BITS out of range");
    end

    state_t               state_r, state_next_s;
    logic [ADDR_BITS-1:0] addr_r, addr_next_s, addr_shift_s, addr_inc_s, rd_addr_s;
    logic [1:0]           cnt_r, cnt_next_s;
    logic                 bad_cmd_r, bad_next_s, busy_r;
    logic                 trig_mem_s, trig_const_s, flush_s;
    logic [7:0]           const_byte_s;
`ifdef SPI_FAST_READ_EN
    logic                 fast_r, fast_next_s;
`endif

    // Upper bits of the 24-bit SPI address fall off the top of the shift
    assign addr_shift_s = ADDR_BITS'({addr_r, rx_data});
    assign addr_inc_s   = addr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    assign flush_s      = spi_cs | reset;
    assign bad_cmd      = bad_cmd_r;
    assign busy         = busy_r;

    // Command state register
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_r   <= ST_CMD;
            addr_r    <= {ADDR_BITS{1'b0}};
            cnt_r     <= 2'd0;
            bad_cmd_r <= 1'b0;
            busy_r    <= 1'b0;
`ifdef SPI_FAST_READ_EN
            fast_r    <= 1'b0;
`endif
        end else begin
            state_r   <= state_next_s;
            addr_r    <= addr_next_s;
            cnt_r     <= cnt_next_s;
            bad_cmd_r <= bad_next_s;
            busy_r    <= (state_next_s != ST_CMD);
`ifdef SPI_FAST_READ_EN
            fast_r    <= fast_next_s;
`endif
        end
    end

    // Byte decode: next state and pipeline triggers
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        cnt_next_s   = cnt_r;
        bad_next_s   = 1'b0;
        trig_mem_s   = 1'b0;
        trig_const_s = 1'b0;
        const_byte_s = 8'h00;
        rd_addr_s    = addr_r;
`ifdef SPI_FAST_READ_EN
        fast_next_s  = fast_r;
`endif
        if (spi_cs) begin
            state_next_s = ST_CMD;
            addr_next_s  = {ADDR_BITS{1'b0}};
            cnt_next_s   = 2'd0;
`ifdef SPI_FAST_READ_EN
            fast_next_s  = 1'b0;
`endif
        end else if (rx_strobe) begin
            case (state_r)
                ST_CMD: begin
                    cnt_next_s = 2'd0;
                    case (rx_data)
                        OP_READ: begin
                            state_next_s = ST_ADDR;
`ifdef SPI_FAST_READ_EN
                            fast_next_s  = 1'b0;
                        end
                        OP_FAST_READ: begin
                            state_next_s = ST_ADDR;
                            fast_next_s  = 1'b1;
`endif
                        end
                        OP_RDID: begin
                            state_next_s = ST_ID;
                            trig_const_s = 1'b1;
                            const_byte_s = JEDEC_ID[23:16];
                        end
                        OP_RDSR: begin
                            state_next_s = ST_STATUS;
                            trig_const_s = 1'b1;
                            const_byte_s = STATUS_BYTE;
                        end
                        default: begin
                            state_next_s = ST_IGNORE;
                            bad_next_s   = 1'b1;
                        end
                    endcase
                end
                ST_ADDR: begin
                    addr_next_s = addr_shift_s;
                    if (cnt_r == 2'd2) begin
                        cnt_next_s = 2'd0;
`ifdef SPI_FAST_READ_EN
                        if (fast_r) begin
                            state_next_s = ST_DUMMY;
                        end else begin
                            state_next_s = ST_DATA;
                            trig_mem_s   = 1'b1;
                            rd_addr_s    = addr_shift_s;
                        end
`else
                        state_next_s = ST_DATA;
                        trig_mem_s   = 1'b1;
                        rd_addr_s    = addr_shift_s;
`endif
                    end else begin
                        cnt_next_s = cnt_r + 2'd1;
                    end
                end
`ifdef SPI_FAST_READ_EN
                ST_DUMMY: begin
                    state_next_s = ST_DATA;
                    trig_mem_s   = 1'b1;
                    rd_addr_s    = addr_r;
                end
`endif
                ST_DATA: begin
                    addr_next_s = addr_inc_s;
                    trig_mem_s  = 1'b1;
                    rd_addr_s   = addr_inc_s;
                end
                ST_ID: begin
                    if (cnt_r != 2'd2) begin
                        trig_const_s = 1'b1;
                        const_byte_s = (cnt_r == 2'd0) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
                        cnt_next_s   = cnt_r + 2'd1;
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                ST_STATUS: begin
                    trig_const_s = 1'b1;
                    const_byte_s = STATUS_BYTE;
                end
                ST_IGNORE: begin
                    state_next_s = ST_IGNORE;
                end
                default: begin
                    state_next_s = ST_CMD;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    spi_flash_read_pipe #(
        .ADDR_BITS (ADDR_BITS)
    ) u_read_pipe (
        .mclk       (mclk),
        .reset      (reset),
        .flush      (flush_s),
        .trig_mem   (trig_mem_s),
        .trig_const (trig_const_s),
        .const_byte (const_byte_s),
        .trig_addr  (rd_addr_s),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tx_strobe  (tx_strobe),
        .tx_data    (tx_data)
    );

endmodule
